// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: byte-level peek/poke responder behind the uart block.
// 'W' addr data -> bus write + ACK, 'R' addr -> bus read + data, else NAK.
module uart_reg_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1_200_000,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B,
    parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_busy,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic [7:0] bus_rdata
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS_WR,
        BUS_RD,
        RD_CAP,
        TX_START,
        TX_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic          op_wr_q, op_wr_d;
    logic          nak_hold_q, nak_hold_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    resp_q, resp_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          re_q, re_d;

    always_comb begin
        state_d    = state_q;
        op_wr_d    = op_wr_q;
        nak_hold_d = 1'b0;
        cnt_d      = cnt_q;
        resp_d     = resp_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_valid) begin
                    if (rx_data == OP_WR || rx_data == OP_RD) begin
                        op_wr_d = (rx_data == OP_WR);
                        state_d = GET_ADDR;
                    end else begin
                        // NAK is loaded this cycle and goes out one later
                        resp_d     = NAK_BYTE;
                        nak_hold_d = 1'b1;
                        state_d    = TX_START;
                    end
                end
            end
            GET_ADDR: begin
                cnt_d = cnt_q + CW'(1);
                if (rx_valid) begin
                    cnt_d  = '0;
                    addr_d = rx_data;
                    if (op_wr_q) begin
                        state_d = GET_DATA;
                    end else begin
                        re_d    = 1'b1;
                        state_d = BUS_RD;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            GET_DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (rx_valid) begin
                    cnt_d   = '0;
                    wdata_d = rx_data;
                    we_d    = 1'b1;
                    state_d = BUS_WR;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            BUS_WR: begin
                resp_d  = ACK_BYTE;
                state_d = TX_START;
            end
            BUS_RD: begin
                state_d = RD_CAP;
            end
            RD_CAP: begin
                resp_d  = bus_rdata;
                state_d = TX_START;
            end
            TX_START: begin
                if (!nak_hold_q && !tx_busy) begin
                    state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // busy must be seen before accepting a new command
                if (tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_wr_q    <= 1'b0;
            nak_hold_q <= 1'b0;
            cnt_q      <= '0;
            resp_q     <= 8'h00;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_wr_q    <= op_wr_d;
            nak_hold_q <= nak_hold_d;
            cnt_q      <= cnt_d;
            resp_q     <= resp_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
        end
    end

    assign tx_data   = resp_q;
    assign tx_send   = (state_q == TX_START) && !nak_hold_q && !tx_busy;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_we    = we_q;
    assign bus_re    = re_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb_uart_reg_bridge: randomized command stream against a
// command-level model of bus strobes and response timing.
module tb_uart_reg_bridge;
    localparam int TO = 16;
    localparam logic [7:0] ACK = 8'h4B;
    localparam logic [7:0] NAK = 8'h3F;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy = 1'b0;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata = 8'h00;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_until = 0;
    int stall_until = 0;
    int rd_cycle = -1;
    logic [7:0] rd_val = 8'h00;

    int          we_c[$];
    logic [15:0] we_v[$];
    int          re_c[$];
    logic [7:0]  re_a[$];
    int          tx_c[$];
    logic [7:0]  tx_v[$];
    int we_i = 0;
    int re_i = 0;
    int tx_i = 0;

    uart_reg_bridge #(
        .TIMEOUT_CYCLES(TO),
        .ACK_BYTE(ACK),
        .NAK_BYTE(NAK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_send(tx_send),
        .tx_busy(tx_busy),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_we(bus_we),
        .bus_re(bus_re),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // transmitter model: busy for a few cycles after each send
    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        tx_busy = (cyc < busy_until) || (cyc < stall_until);
    end

    always @(negedge clk) begin
        if (bus_we) begin
            we_c.push_back(cyc);
            we_v.push_back({bus_addr, bus_wdata});
        end
        if (bus_re) begin
            re_c.push_back(cyc);
            re_a.push_back(bus_addr);
        end
        if (tx_send) begin
            tx_c.push_back(cyc);
            tx_v.push_back(tx_data);
            busy_until = cyc + 1 + int'($urandom_range(2, 6));
        end
    end

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic int rnd(input int m);
        return int'($urandom_range(0, m));
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h want 'h%0h @%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (cyc == rd_cycle) begin
            bus_rdata = rd_val;
        end else begin
            bus_rdata = rd_val ^ 8'($urandom_range(1, 255));
        end
    endtask

    task automatic put(input logic [7:0] b, input int gap, output int c);
        repeat (gap) step();
        step();
        rx_valid = 1'b1;
        rx_data = b;
        c = cyc;
    endtask

    task automatic expect_events(
        input int n_we, input int we_cy, input logic [15:0] we_val,
        input int n_re, input int re_cy, input logic [7:0] re_addr,
        input int n_tx, input int tx_cy, input logic [7:0] tx_val
    );
        chk("we_count", we_c.size() - we_i, n_we);
        if (n_we == 1 && we_c.size() > we_i) begin
            chk("we_cycle", we_c[we_i], we_cy);
            chk("we_addr_data", int'(we_v[we_i]), int'(we_val));
        end
        chk("re_count", re_c.size() - re_i, n_re);
        if (n_re == 1 && re_c.size() > re_i) begin
            chk("re_cycle", re_c[re_i], re_cy);
            chk("re_addr", int'(re_a[re_i]), int'(re_addr));
        end
        chk("tx_count", tx_c.size() - tx_i, n_tx);
        if (n_tx == 1 && tx_c.size() > tx_i) begin
            chk("tx_cycle", tx_c[tx_i], tx_cy);
            chk("tx_data", int'(tx_v[tx_i]), int'(tx_val));
        end
        we_i = we_c.size();
        re_i = re_c.size();
        tx_i = tx_c.size();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_tx_send", int'(tx_send), 0);
        chk("rst_bus_addr", int'(bus_addr), 0);
        chk("rst_bus_wdata", int'(bus_wdata), 0);
        chk("rst_bus_we", int'(bus_we), 0);
        chk("rst_bus_re", int'(bus_re), 0);
    endtask

    // kind 0 write, 1 read, 2 unknown opcode byte a, 3 abandoned partial
    task automatic do_cmd(
        input int kind, input logic [7:0] a, input logic [7:0] d,
        input logic [7:0] rv, input int gfix, input int gmax,
        input bit stall, input bit junk, input int sil
    );
        int c0, c1, c2, last, k, exp_tx, g;
        logic [7:0] resp;
        c1 = 0;
        k = 0;
        resp = 8'h00;
        g = (gfix >= 0) ? gfix : rnd(gmax);
        if (kind == 3) begin
            put(a, g, c0);
            if (a == 8'h57) begin
                put(d, rnd(gmax), c1);
            end
            repeat (TO + sil) step();
            expect_events(0, 0, 16'h0, 0, 0, 8'h0, 0, 0, 8'h0);
            return;
        end
        if (kind == 0) begin
            put(8'h57, g, c0);
            put(a, (gfix >= 0) ? gfix : rnd(gmax), c1);
            put(d, (gfix >= 0) ? gfix : rnd(gmax), c2);
            last = c2;
            k = 2;
            resp = ACK;
        end else if (kind == 1) begin
            put(8'h52, g, c0);
            put(a, (gfix >= 0) ? gfix : rnd(gmax), c1);
            rd_cycle = c1 + 2;
            rd_val = rv;
            last = c1;
            k = 3;
            resp = rv;
        end else begin
            put(a, g, c0);
            last = c0;
            k = 2;
            resp = NAK;
        end
        if (stall) begin
            stall_until = last + 1 + 50;
        end
        exp_tx = imax(last + k, imax(busy_until, stall_until));
        while (cyc < exp_tx + 2) begin
            step();
            if (junk && cyc > last && cyc < exp_tx && rnd(2) == 0) begin
                rx_valid = 1'b1;
                rx_data = 8'($urandom);
            end
        end
        expect_events(
            (kind == 0) ? 1 : 0, last + 1, {a, d},
            (kind == 1) ? 1 : 0, last + 1, a,
            1, exp_tx, resp
        );
    endtask

    initial begin
        int c0, c1, kind;
        logic [7:0] b;
        reset = 1'b1;
        repeat (3) step();
        chk_reset_outputs();
        reset = 1'b0;

        do_cmd(0, 8'h10, 8'hA5, 8'h00, 0, 0, 1'b0, 1'b0, 0);
        do_cmd(1, 8'h22, 8'h00, 8'h3C, 0, 0, 1'b0, 1'b0, 0);
        chk("addr_held", int'(bus_addr), 8'h22);
        chk("wdata_held", int'(bus_wdata), 8'hA5);
        do_cmd(2, 8'h41, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 0);
        do_cmd(1, 8'h05, 8'h00, 8'h9E, 0, 0, 1'b0, 1'b0, 0);
        do_cmd(3, 8'h57, 8'h10, 8'h00, 0, 0, 1'b0, 1'b0, 0);
        do_cmd(1, 8'h07, 8'h00, 8'h61, 0, 0, 1'b0, 1'b0, 0);
        do_cmd(0, 8'h33, 8'h5C, 8'h00, 15, 0, 1'b0, 1'b0, 0);
        do_cmd(1, 8'h44, 8'h00, 8'hC3, 15, 0, 1'b0, 1'b0, 0);
        do_cmd(0, 8'h12, 8'h34, 8'h00, 0, 0, 1'b1, 1'b1, 0);
        do_cmd(2, 8'h00, 8'h00, 8'h00, 0, 0, 1'b1, 1'b1, 0);

        put(8'h57, 0, c0);
        put(8'h10, 0, c1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_outputs();
        repeat (3) step();
        expect_events(0, 0, 16'h0, 0, 0, 8'h0, 0, 0, 8'h0);
        do_cmd(2, 8'hA5, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            kind = rnd(3);
            if (kind == 2) begin
                do begin
                    b = 8'($urandom);
                end while (b == 8'h57 || b == 8'h52);
            end else if (kind == 3) begin
                b = (rnd(1) == 0) ? 8'h57 : 8'h52;
            end else begin
                b = 8'($urandom);
            end
            do_cmd(kind, b, 8'($urandom), 8'($urandom), -1,
                (rnd(3) == 0) ? 15 : 3, rnd(7) == 0, rnd(1) == 1,
                rnd(4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Byte-level command responder sitting on the far side of the `uart` block. It consumes received bytes, decodes a 2- or 3-byte register-access protocol, and performs single-cycle reads and writes on an internal 8-bit register bus. It returns one response byte per command through the UART transmit handshake, giving a host PC peek/poke access to FPGA registers over the serial link.

## Interface
- `TIMEOUT_CYCLES`, default 1_200_000: idle clocks allowed between bytes of one command before the partial command is discarded (100 ms at 12 MHz).
- `ACK_BYTE`, default 8'h4B ('K'): response to a completed write.
- `NAK_BYTE`, default 8'h3F ('?'): response to an unknown command byte.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: received byte; valid in the cycle `rx_valid` is high.
- `rx_valid` in 1: single-cycle pulse per received byte (UART `received_data_intr`).
- `tx_data` out 8: response byte; held stable from the `tx_send` cycle until `tx_busy` is seen high.
- `tx_send` out 1: single-cycle request to transmit `tx_data`.
- `tx_busy` in 1: transmitter busy; rises the cycle after an accepted `tx_send`.
- `bus_addr` out 8: register address.
- `bus_wdata` out 8: write data.
- `bus_we` out 1: single-cycle write strobe.
- `bus_re` out 1: single-cycle read strobe.
- `bus_rdata` in 8: read data, valid the cycle after `bus_re`.

## Operation
- Protocol:
  - Write is 8'h57 ('W'), addr, data. Response is `ACK_BYTE`.
  - Read is 8'h52 ('R'), addr. Response is the register value.
  - Any other first byte gets response `NAK_BYTE`; no bus access.
- States: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_CAP, TX_START, TX_WAIT.
- IDLE, on `rx_valid`:
  - 'W' or 'R': latch the opcode and go to GET_ADDR.
  - Any other byte: load `NAK_BYTE` into the response register and go to TX_START.
- GET_ADDR, on `rx_valid`:
  - Latch `bus_addr` from `rx_data`.
  - Write opcode: go to GET_DATA.
  - Read opcode: go to BUS_RD.
- GET_DATA, on `rx_valid`: latch `bus_wdata` from `rx_data`, then go to BUS_WR.
- BUS_WR: `bus_we`=1 for exactly this cycle. Load `ACK_BYTE` and go to TX_START.
- BUS_RD: `bus_re`=1 for exactly this cycle, then go to RD_CAP.
- RD_CAP: capture `bus_rdata` into the response register, then go to TX_START.
- TX_START: wait while `tx_busy`=1. When `tx_busy`=0, pulse `tx_send` for one cycle with `tx_data` equal to the response, then go to TX_WAIT.
- TX_WAIT: return to IDLE on the first cycle `tx_busy`=1. This prevents a double send before busy rises.
- Inter-byte timeout:
  - The counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry to GET_ADDR/GET_DATA and on every accepted byte.
  - It increments in GET_ADDR/GET_DATA only.
  - When it reaches `TIMEOUT_CYCLES`-1 without `rx_valid`: go to IDLE with no response and no bus access.
  - If `rx_valid` arrives in the same cycle as the timeout, the byte wins.
- `rx_valid` in BUS_WR, BUS_RD, RD_CAP, TX_START or TX_WAIT is ignored and the byte is dropped. The host must wait for the response before sending the next command.
- `bus_addr`/`bus_wdata` hold their last values between commands.

## Timing
- Reset values:
  - `tx_send`, `bus_we`, `bus_re` = 0.
  - `tx_data`, `bus_addr`, `bus_wdata` = 8'h00.
  - State is IDLE; timeout counter is 0.
- Reset mid-command or mid-response: abort immediately. No further `tx_send` or bus strobes are issued.
- Write, with the data byte `rx_valid` at cycle N:
  - `bus_we`=1 at N+1 with addr/wdata stable.
  - `tx_send` at N+2 if `tx_busy`=0.
- Read, with the addr byte `rx_valid` at cycle N:
  - `bus_re`=1 at N+1.
  - `bus_rdata` is sampled at N+2.
  - `tx_send` at N+3 if `tx_busy`=0.
- NAK, with the bad byte at cycle N: `tx_send` at N+2 (N+1 loads the response, via TX_START).
- `tx_busy` stalls delay `tx_send` only; the response byte is unaffected.
- At most one `tx_send` per command; exactly one bus strobe per valid command.

## Test plan
- Write: bytes 57,10,A5 → one `bus_we` pulse with addr=10, wdata=A5; then `tx_send` with `tx_data`=4B at the cycle counts above.
- Read: bytes 52,22 with `bus_rdata`=3C at the cycle after `bus_re` → one `bus_re` with addr=22; `tx_data`=3C.
- Unknown: byte 41 → `tx_data`=3F; no `bus_we`/`bus_re`. A following 52,05 is then decoded normally.
- Timeout (`TIMEOUT_CYCLES`=16): 57,10, then silence for 16 cycles, then 52,07 → no write, no response for the first command; a read of 07 and its response follow.
- TX stall: hold `tx_busy`=1 for 50 cycles when the response is ready → `tx_send` fires exactly once, the cycle after `tx_busy` drops; extra `rx_valid` bytes during the stall are dropped.
- Reset after 57,10 (mid-command) → all outputs reset; a subsequent A5 is treated as an unknown command and gets response 3F.
